// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point divider: FSM states, flag bit
// positions and the canonical quiet-NaN pattern.
package fp_pkg;

  typedef enum logic [1:0] {IDLE, ITER, ROUND, DONE} state_t;

  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_DIVZERO   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  // {0, all-ones exponent, fraction MSB set, rest zero}, right-aligned in 64 bits.
  function automatic logic [63:0] canon_nan(input int ew, input int mw);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < ew; i++) v[mw+i] = 1'b1;
    v[mw-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits one operand into fields and classifies it; exponent zero counts as
// zero, so denormals are flushed.
module fp_unpack #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic [EW+MW:0] a,
  output logic           sign,
  output logic [EW-1:0]  exponent,
  output logic [MW:0]    sig,
  output logic           is_zero,
  output logic           is_inf,
  output logic           is_nan
);

  logic exp_ones;
  logic frac_nz;

  assign sign     = a[EW+MW];
  assign exponent = a[MW +: EW];
  assign sig      = {1'b1, a[MW-1:0]};
  assign exp_ones = &exponent;
  assign frac_nz  = |a[MW-1:0];
  assign is_zero  = (exponent == '0);
  assign is_inf   = exp_ones & ~frac_nz;
  assign is_nan   = exp_ones & frac_nz;

endmodule

// File: rtl/fp_div_unit.sv
// Fixed-latency floating-point divider: one restoring quotient bit per cycle,
// then a single round-to-nearest-even step.
module fp_div_unit
  import fp_pkg::*;
#(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic [EW+MW:0] x,
  input  logic [EW+MW:0] y,
  output logic           stall,
  output logic [EW+MW:0] z,
  output logic [4:0]     flags
);

  localparam int W    = 1 + EW + MW;
  localparam int N    = MW + 3;
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam int CW   = $clog2(N);
  localparam logic [W-1:0]  QNAN  = W'(canon_nan(EW, MW));
  localparam logic [EW+1:0] BIAS_E = (EW+2)'(BIAS);
  localparam logic [EW+1:0] MAX_E  = (EW+2)'((1 << EW) - 1);

  logic          xs, ys, xz, yz, xi, yi, xn, yn;
  logic [EW-1:0] xe, ye;
  logic [MW:0]   xm, ym;

  fp_unpack #(.EW(EW), .MW(MW)) u_unpack_x (
    .a(x), .sign(xs), .exponent(xe), .sig(xm), .is_zero(xz), .is_inf(xi), .is_nan(xn)
  );
  fp_unpack #(.EW(EW), .MW(MW)) u_unpack_y (
    .a(y), .sign(ys), .exponent(ye), .sig(ym), .is_zero(yz), .is_inf(yi), .is_nan(yn)
  );

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic          sign_reg, xz_reg, yz_reg, xi_reg, yi_reg, xn_reg, yn_reg;
  logic [EW-1:0] xe_reg, ye_reg;
  logic [MW:0]   my_reg;
  logic [MW+1:0] rem_reg;
  logic [N-1:0]  q_reg;
  logic [W-1:0]  z_reg;
  logic [4:0]    flags_reg;

  // Restoring step: remainder stays below 2*divisor, so MW+2 bits suffice.
  logic          ge;
  logic [MW+1:0] diff, rem_next;
  assign ge       = (rem_reg >= {1'b0, my_reg});
  assign diff     = rem_reg - {1'b0, my_reg};
  assign rem_next = ge ? {diff[MW:0], 1'b0} : {rem_reg[MW:0], 1'b0};

  logic          msb, guard, sticky, round_up, carry;
  logic [MW:0]   sig_n;
  logic [MW+1:0] sum;
  logic [MW-1:0] frac;
  logic [EW+1:0] e_calc;
  logic          ovf, unf;

  assign msb      = q_reg[N-1];
  assign sig_n    = msb ? q_reg[N-1 -: MW+1] : q_reg[N-2 -: MW+1];
  assign guard    = msb ? q_reg[1] : q_reg[0];
  assign sticky   = (msb & q_reg[0]) | (|rem_reg);
  assign round_up = guard & (sticky | sig_n[0]);
  assign sum      = {1'b0, sig_n} + {{(MW+1){1'b0}}, round_up};
  assign carry    = sum[MW+1];
  assign frac     = carry ? sum[MW:1] : sum[MW-1:0];
  assign e_calc   = {2'b00, xe_reg} - {2'b00, ye_reg} + BIAS_E
                  - {{(EW+1){1'b0}}, ~msb} + {{(EW+1){1'b0}}, carry};
  assign ovf      = ~e_calc[EW+1] && (e_calc >= MAX_E);
  assign unf      = e_calc[EW+1] || (e_calc == '0);

  logic [W-1:0] z_new;
  logic [4:0]   flags_new;

  always_comb begin
    z_new     = '0;
    flags_new = '0;
    if (xn_reg | yn_reg) begin
      z_new = QNAN;
    end else if ((xz_reg & yz_reg) | (xi_reg & yi_reg)) begin
      z_new = QNAN;
      flags_new[FLAG_INVALID] = 1'b1;
    end else if (xi_reg) begin
      z_new = {sign_reg, {EW{1'b1}}, {MW{1'b0}}};
    end else if (yi_reg) begin
      z_new = {sign_reg, {(EW+MW){1'b0}}};
    end else if (yz_reg) begin
      z_new = {sign_reg, {EW{1'b1}}, {MW{1'b0}}};
      flags_new[FLAG_DIVZERO] = 1'b1;
    end else if (xz_reg) begin
      z_new = {sign_reg, {(EW+MW){1'b0}}};
    end else if (ovf) begin
      z_new = {sign_reg, {EW{1'b1}}, {MW{1'b0}}};
      flags_new[FLAG_OVERFLOW] = 1'b1;
      flags_new[FLAG_INEXACT]  = 1'b1;
    end else if (unf) begin
      z_new = {sign_reg, {(EW+MW){1'b0}}};
      flags_new[FLAG_UNDERFLOW] = 1'b1;
      flags_new[FLAG_INEXACT]   = 1'b1;
    end else begin
      z_new = {sign_reg, e_calc[EW-1:0], frac};
      flags_new[FLAG_INEXACT] = guard | sticky;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      z_reg     <= '0;
      flags_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: if (run) begin
          sign_reg  <= xs ^ ys;
          xe_reg    <= xe;
          ye_reg    <= ye;
          my_reg    <= ym;
          rem_reg   <= {1'b0, xm};
          q_reg     <= '0;
          xz_reg    <= xz;
          yz_reg    <= yz;
          xi_reg    <= xi;
          yi_reg    <= yi;
          xn_reg    <= xn;
          yn_reg    <= yn;
          cnt_reg   <= '0;
          state_reg <= ITER;
        end
        ITER: if (!run) begin
          state_reg <= IDLE;
        end else begin
          rem_reg <= rem_next;
          q_reg   <= {q_reg[N-2:0], ge};
          if (cnt_reg == CW'(N - 1)) state_reg <= ROUND;
          else                       cnt_reg   <= cnt_reg + 1'b1;
        end
        ROUND: if (!run) begin
          state_reg <= IDLE;
        end else begin
          z_reg     <= z_new;
          flags_reg <= flags_new;
          state_reg <= DONE;
        end
        default: if (!run) state_reg <= IDLE;
      endcase
    end
  end

  assign stall = run & (rst | (state_reg != DONE));
  assign z     = z_reg;
  assign flags = flags_reg;

endmodule

// File: tb/tb_fp_div_unit.sv
// Bench for fp_div_unit (single precision): scoreboarded operations, latency,
// special cases, abort and mid-operation reset.
module tb_fp_div_unit;

  logic        clk = 1'b0;
  logic        rst, run;
  logic [31:0] x, y, z;
  logic        stall;
  logic [4:0]  flags;

  always #5 clk = ~clk;

  fp_div_unit #(.EW(8), .MW(23)) dut (
    .clk(clk), .rst(rst), .run(run), .x(x), .y(y),
    .stall(stall), .z(z), .flags(flags)
  );

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [31:0] z;
    logic [4:0]  f;
    string       name;
  } exp_t;
  exp_t sb[$];

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ez, input logic [4:0] ef, input string name);
    exp_t e;
    int   cyc;
    logic done;
    e.z = ez; e.f = ef; e.name = name;
    sb.push_back(e);
    @(posedge clk); #1;
    x = a; y = b; run = 1'b1;
    cyc = 0; done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (i == 1) begin x = $urandom; y = $urandom; end
      if (stall) cyc++;
      else       done = 1'b1;
    end
    e = sb.pop_front();
    total++;
    if (cyc !== 28) $display("FAIL %s latency: got %0d cycles, expected 28", e.name, cyc);
    else passed++;
    total++;
    if (z !== e.z) $display("FAIL %s z: got %08h, expected %08h", e.name, z, e.z);
    else passed++;
    total++;
    if (flags !== e.f) $display("FAIL %s flags: got %05b, expected %05b", e.name, flags, e.f);
    else passed++;
    $display("op %-12s %08h / %08h -> z=%08h flags=%05b cycles=%0d", e.name, a, b, z, flags, cyc);
    @(posedge clk); #1;
    run = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; x = '0; y = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (z !== 32'h0) $display("FAIL reset_z: got %08h, expected 00000000", z); else passed++;
    total++;
    if (flags !== 5'b0) $display("FAIL reset_flags: got %05b, expected 00000", flags); else passed++;
    total++;
    if (stall !== 1'b0) $display("FAIL reset_stall_lo: got %b, expected 0", stall); else passed++;
    run = 1'b1; #1;
    total++;
    if (stall !== 1'b1) $display("FAIL reset_stall_hi: got %b, expected 1", stall); else passed++;
    @(posedge clk); #1;
    run = 1'b0; rst = 1'b0;
    $display("reset: z=%08h flags=%05b", z, flags);
  endtask

  task automatic test_normal();
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, "6/2");
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, "1/3");
    run_op(32'hC0C00000, 32'h40000000, 32'hC0400000, 5'b00000, "-6/2");
    run_op(32'h40000000, 32'h40800000, 32'h3F000000, 5'b00000, "2/4");
  endtask

  task automatic test_specials();
    run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, "1/0");
    run_op(32'hBF800000, 32'h00000000, 32'hFF800000, 5'b01000, "-1/0");
    run_op(32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, "0/0");
    run_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b00000, "nan/1");
    run_op(32'h3F800000, 32'h7F800001, 32'h7FC00000, 5'b00000, "1/nan");
    run_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000, "inf/inf");
    run_op(32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, "-inf/2");
    run_op(32'h40000000, 32'hFF800000, 32'h80000000, 5'b00000, "2/-inf");
    run_op(32'h00000000, 32'h40A00000, 32'h00000000, 5'b00000, "0/5");
  endtask

  task automatic test_boundaries();
    run_op(32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101, "overflow");
    run_op(32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, "underflow");
    run_op(32'h00400000, 32'h3F800000, 32'h00000000, 5'b00000, "denorm/1");
    run_op(32'h3F800000, 32'h00000001, 32'h7F800000, 5'b01000, "1/denorm");
  endtask

  task automatic test_abort();
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, "pre_abort");
    @(posedge clk); #1;
    x = 32'h3F800000; y = 32'h40400000; run = 1'b1;
    repeat (10) @(negedge clk);
    run = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (z !== 32'h40400000) $display("FAIL abort_z: got %08h, expected 40400000", z); else passed++;
    total++;
    if (flags !== 5'b0) $display("FAIL abort_flags: got %05b, expected 00000", flags); else passed++;
    $display("abort: z=%08h flags=%05b", z, flags);
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, "post_abort");
  endtask

  task automatic test_reset_mid();
    logic done;
    @(posedge clk); #1;
    x = 32'h40C00000; y = 32'h40000000; run = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1; #1;
    total++;
    if (stall !== 1'b1) $display("FAIL rst_mid_stall: got %b, expected 1", stall); else passed++;
    @(posedge clk); #1;
    rst = 1'b0; run = 1'b0;
    @(negedge clk);
    total++;
    if (z !== 32'h0) $display("FAIL rst_mid_z: got %08h, expected 00000000", z); else passed++;
    total++;
    if (flags !== 5'b0) $display("FAIL rst_mid_flags: got %05b, expected 00000", flags); else passed++;
    $display("reset mid-op: z=%08h flags=%05b", z, flags);
    // Reset while parked in DONE with run still high.
    @(posedge clk); #1;
    x = 32'h40C00000; y = 32'h40000000; run = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
    end
    total++;
    if (!done) $display("FAIL done_wait: stall still high after 100 cycles, expected low");
    else passed++;
    rst = 1'b1; #1;
    total++;
    if (stall !== 1'b1) $display("FAIL rst_done_stall: got %b, expected 1", stall); else passed++;
    @(posedge clk); #1;
    rst = 1'b0; run = 1'b0;
    @(posedge clk); #1;
    $display("reset in done: stall followed run");
    run_op(32'h40000000, 32'h40800000, 32'h3F000000, 5'b00000, "post_reset");
  endtask

  task automatic test_back_to_back();
    run_op(32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, "1/1");
    run_op(32'h40400000, 32'hC0400000, 32'hBF800000, 5'b00000, "3/-3");
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, "1/3_again");
  endtask

  initial begin
    test_reset();
    test_normal();
    test_specials();
    test_boundaries();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
